// File: rtl/fft_fixed_pkg.sv
// Shared Q4.4 fixed-point constants, FSM state encoding and the quotient
// sign/saturation mapping used by the complex divider.
package fft_fixed_pkg;

   localparam int W    = 8;
   localparam int FRAC = 4;

   localparam logic [W-1:0] Q44_MAX = 8'h7F;
   localparam logic [W-1:0] Q44_MIN = 8'h80;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      DIV_RE,
      DIV_IM,
      DONE
   } state_t;

   // q is the unsigned magnitude quotient; Q44_MIN doubles as 2^(W-1),
   // which is the largest magnitude a negative result can still represent.
   function automatic logic [W-1:0] sat_map(input logic neg,
                                            input logic sat,
                                            input logic [W-1:0] q);
      logic [W-1:0] r;
      if (neg)
         r = (sat || (q > Q44_MIN)) ? Q44_MIN : (~q + 1'b1);
      else
         r = (sat || (q > Q44_MAX)) ? Q44_MAX : q;
      return r;
   endfunction

endpackage

// File: rtl/udiv_restoring_serial.sv
// Serial unsigned restoring divider: QW quotient bits, MSB first, one per
// clock. The first bit is resolved on the start edge itself.
module udiv_restoring_serial #(
   parameter int QW = 8,
   parameter int DW = 21,
   parameter int VW = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [QW-1:0] quotient
);
   localparam int XW = VW + QW - 1;
   localparam int CW = $clog2(QW);

   logic [XW-1:0] rem, dsh, rem_src, dsh_src, rem_next;
   logic [QW-1:0] q, q_src, q_next;
   logic [CW-1:0] cnt;
   logic          ge;

   // NOTE: every variable written here gets a value before any branch so
   // that no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rem_src  = start ? XW'(dividend) : rem;
      dsh_src  = start ? {divisor, {(QW-1){1'b0}}} : dsh;
      q_src    = start ? '0 : q;
      ge       = (rem_src >= dsh_src);
      rem_next = ge ? (rem_src - dsh_src) : rem_src;
      q_next   = (q_src << 1) | QW'(ge);
   end

   // Quotient is presented combinationally so the final bit is usable in
   // the same cycle that done is high.
   assign done     = busy && (cnt == CW'(QW - 1));
   assign quotient = q_next;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cnt  <= '0;
         rem  <= '0;
         dsh  <= '0;
         q    <= '0;
      end else begin
         if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(1);
         end else if (busy) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(QW - 1))
               busy <= 1'b0;
         end
         if (start || busy) begin
            rem <= rem_next;
            dsh <= dsh_src >> 1;
            q   <= q_next;
         end
      end
   end

endmodule

// File: rtl/complex_div_seq.sv
// Sequential Q4.4 complex divider (a+j*aj)/(b+j*bj): multiply by the conjugate,
// then divide real and imaginary magnitudes through one shared serial divider.
module complex_div_seq
   import fft_fixed_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] aj,
   input  logic [W-1:0] b,
   input  logic [W-1:0] bj,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] c,
   output logic [W-1:0] cj,
   output logic         div_zero
);
   localparam int PW = 2*W + 1;
   localparam int DW = PW + FRAC;

   state_t state, next_state;

   logic [W-1:0]  a_r, aj_r, b_r, bj_r;
   logic [PW-1:0] mag_re, mag_im, den_r;
   logic          neg_re, neg_im, sat_re, sat_im;
   logic [W-1:0]  q_re;

   logic signed [PW-1:0] ax, ajx, bx, bjx, num_re, num_im, den_c;
   logic [PW-1:0]        mag_re_c, mag_im_c;
   logic                 sat_re_c, sat_im_c, den_zero;

   logic          div_start, div_busy, div_done;
   logic [DW-1:0] div_dividend;
   logic [W-1:0]  div_q;

   // Conjugate products at 2W+1 bits so -0x80 operands cannot overflow.
   assign ax  = {{(PW-W){a_r[W-1]}},  a_r};
   assign ajx = {{(PW-W){aj_r[W-1]}}, aj_r};
   assign bx  = {{(PW-W){b_r[W-1]}},  b_r};
   assign bjx = {{(PW-W){bj_r[W-1]}}, bj_r};

   assign num_re = ax * bx + ajx * bjx;
   assign num_im = ajx * bx - ax * bjx;
   assign den_c  = bx * bx + bjx * bjx;

   assign mag_re_c = num_re[PW-1] ? -num_re : num_re;
   assign mag_im_c = num_im[PW-1] ? -num_im : num_im;
   assign sat_re_c = (DW'(mag_re_c) >= {den_c, {FRAC{1'b0}}});
   assign sat_im_c = (DW'(mag_im_c) >= {den_c, {FRAC{1'b0}}});
   assign den_zero = (den_c == '0);

   assign div_start    = ((state == DIV_RE) || (state == DIV_IM)) && !div_busy;
   assign div_dividend = (state == DIV_IM) ? {mag_im, {FRAC{1'b0}}}
                                           : {mag_re, {FRAC{1'b0}}};

   udiv_restoring_serial #(
      .QW (W),
      .DW (DW),
      .VW (PW)
   ) u_udiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (den_r),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               next_state = PREP;
         end
         PREP:   next_state = den_zero ? DONE : DIV_RE;
         DIV_RE: if (div_done) next_state = DIV_IM;
         DIV_IM: if (div_done) next_state = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // c/cj/div_zero are written only on the edge that enters DONE, so they
   // hold steady under backpressure without extra enables.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= '0;
         aj_r     <= '0;
         b_r      <= '0;
         bj_r     <= '0;
         mag_re   <= '0;
         mag_im   <= '0;
         den_r    <= '0;
         neg_re   <= 1'b0;
         neg_im   <= 1'b0;
         sat_re   <= 1'b0;
         sat_im   <= 1'b0;
         q_re     <= '0;
         c        <= '0;
         cj       <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r  <= a;
                  aj_r <= aj;
                  b_r  <= b;
                  bj_r <= bj;
               end
            end
            PREP: begin
               mag_re <= mag_re_c;
               mag_im <= mag_im_c;
               den_r  <= den_c;
               neg_re <= num_re[PW-1];
               neg_im <= num_im[PW-1];
               sat_re <= sat_re_c;
               sat_im <= sat_im_c;
               if (den_zero) begin
                  c        <= '0;
                  cj       <= '0;
                  div_zero <= 1'b1;
               end
            end
            DIV_RE: begin
               if (div_done)
                  q_re <= div_q;
            end
            DIV_IM: begin
               if (div_done) begin
                  c        <= sat_map(neg_re, sat_re, q_re);
                  cj       <= sat_map(neg_im, sat_im, div_q);
                  div_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_complex_div_seq.sv
// Randomised and directed self-checking bench for complex_div_seq against an
// integer-arithmetic model of the complex quotient.
module tb_complex_div_seq;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, div_zero;
   logic [7:0] a, aj, b, bj, c, cj;

   int n_checks = 0;
   int n_err    = 0;

   // Latency in edges after the accepting edge; the accepting edge itself is
   // the first of the 18 (normal) or 2 (divide by zero).
   localparam int LAT_NORM = 17;
   localparam int LAT_DZ   = 1;

   always #5 clk = ~clk;

   complex_div_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .aj        (aj),
      .b         (b),
      .bj        (bj),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .cj        (cj),
      .div_zero  (div_zero)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One component: truncate |n|*16/d toward zero, then clamp to Q4.4.
   function automatic logic [7:0] comp(input int n, input int d);
      int m, q;
      m = (n < 0) ? -n : n;
      q = (m * 16) / d;
      if (n < 0)
         return (q > 128) ? 8'h80 : 8'(-q);
      else
         return (q > 127) ? 8'h7F : 8'(q);
   endfunction

   task automatic model(input logic [7:0] ia, iaj, ib, ibj,
                        output logic [7:0] ec, ecj, output logic edz);
      int sa, saj, sb, sbj, nr, ni, d;
      sa  = int'($signed(ia));
      saj = int'($signed(iaj));
      sb  = int'($signed(ib));
      sbj = int'($signed(ibj));
      nr  = sa * sb + saj * sbj;
      ni  = saj * sb - sa * sbj;
      d   = sb * sb + sbj * sbj;
      if (d == 0) begin
         ec = 8'h00; ecj = 8'h00; edz = 1'b1;
      end else begin
         ec = comp(nr, d); ecj = comp(ni, d); edz = 1'b0;
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_ready"}, in_ready, 1);
   endtask

   task automatic wait_out(input string tag, input int exp_lat);
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_lat"}, k, exp_lat);
   endtask

   task automatic check_result(input string tag, input logic [7:0] ia, iaj, ib, ibj);
      logic [7:0] ec, ecj;
      logic       edz;
      model(ia, iaj, ib, ibj, ec, ecj, edz);
      check({tag, "_c"}, c, ec);
      check({tag, "_cj"}, cj, ecj);
      check({tag, "_dz"}, div_zero, edz);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ov_drop"}, out_valid, 0);
      check({tag, "_idle"}, in_ready, 1);
   endtask

   task automatic run_op(input string tag, input logic [7:0] ia, iaj, ib, ibj, input int hold);
      logic [7:0] ec, ecj;
      logic       edz;
      model(ia, iaj, ib, ibj, ec, ecj, edz);
      wait_ready(tag);
      a = ia; aj = iaj; b = ib; bj = ibj;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom); aj = 8'($urandom); b = 8'($urandom); bj = 8'($urandom);
      wait_out(tag, edz ? LAT_DZ : LAT_NORM);
      check_result(tag, ia, iaj, ib, ibj);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
      end
      if (hold > 0) begin
         check({tag, "_hold_ov"}, out_valid, 1);
         check({tag, "_hold_ir"}, in_ready, 0);
         check({tag, "_hold_c"}, c, ec);
         check({tag, "_hold_cj"}, cj, ecj);
      end
      handshake(tag);
   endtask

   initial begin
      logic [7:0] ra, raj, rb, rbj;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; aj = '0; b = '0; bj = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_c", c, 0);
      check("rst_cj", cj, 0);
      check("rst_dz", div_zero, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("one_by_one", 8'h10, 8'h00, 8'h10, 8'h00, 0);
      run_op("half_by_j", 8'h08, 8'h08, 8'h00, 8'h10, 20);
      run_op("trunc_pos", 8'h10, 8'h00, 8'h30, 8'h00, 1);
      run_op("trunc_neg", 8'hF0, 8'h00, 8'h30, 8'h00, 0);
      run_op("sat_pos", 8'h7F, 8'h00, 8'h01, 8'h00, 0);
      run_op("sat_neg", 8'h80, 8'h00, 8'h01, 8'h00, 0);
      run_op("min_ops", 8'h80, 8'h80, 8'h80, 8'h80, 0);

      // Abort in the middle of the real-part division.
      wait_ready("abort");
      a = 8'h30; aj = 8'h00; b = 8'h10; bj = 8'h00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_c", c, 0);
      check("abort_cj", cj, 0);
      check("abort_dz", div_zero, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("after_abort", 8'h30, 8'h10, 8'h10, 8'h00, 0);

      run_op("div_zero", 8'h5A, 8'hC3, 8'h00, 8'h00, 2);

      // Back-to-back: in_valid stays high; the second operand set must wait
      // for the output handshake.
      wait_ready("b2b");
      a = 8'h10; aj = 8'h00; b = 8'h10; bj = 8'h00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      a = 8'h08; aj = 8'h08; b = 8'h00; bj = 8'h10;
      wait_out("b2b_first", LAT_NORM);
      check("b2b_busy_ir", in_ready, 0);
      check_result("b2b_first", 8'h10, 8'h00, 8'h10, 8'h00);
      handshake("b2b_first");
      @(posedge clk); #1;
      check("b2b_second_taken", in_ready, 0);
      in_valid = 1'b0;
      wait_out("b2b_second", LAT_NORM);
      check_result("b2b_second", 8'h08, 8'h08, 8'h00, 8'h10);
      handshake("b2b_second");

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom); raj = 8'($urandom);
         rb = 8'($urandom); rbj = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            rb = 8'h00; rbj = 8'h00;
         end
         run_op("rand", ra, raj, rb, rbj, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
